// File: rtl/or_nway_pipe.sv
// ============================================================================
// Module   : or_nway_pipe
// Purpose  : Pipelined N-way OR/AND/XOR/NOR reduction tree with sticky hit
//            flag and saturating hit counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module or_nway_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       op,
    input  logic             clear,
    output logic             out_valid,
    output logic             out,
    output logic             any_seen,
    output logic [15:0]      hit_count
);

    localparam int LAT        = $clog2(WIDTH);
    // Every level is packed into one vector: level k starts at 2*WIDTH-2*(WIDTH>>k).
    localparam int TOTAL_BITS = 2 * WIDTH - 1;
    localparam int FINAL_BIT  = TOTAL_BITS - 1;

    logic [TOTAL_BITS-1:0] data_d, data_q;
    logic [LAT:0]          valid_d, valid_q;
    logic [LAT-1:0][1:0]   op_d, op_q;
    logic                  any_seen_d, any_seen_q;
    logic [15:0]           hit_count_d, hit_count_q;
    logic                  red_bit;

    function automatic int lvl_off(input int k);
        return 2 * WIDTH - 2 * (WIDTH >> k);
    endfunction

    function automatic logic reduce2(input logic [1:0] sel, input logic a, input logic b);
        case (sel)
            2'b01:   return a & b;
            2'b10:   return a ^ b;
            default: return a | b;
        endcase
    endfunction

    always_comb begin
        data_d            = data_q;
        red_bit           = 1'b0;
        data_d[WIDTH-1:0] = in;
        valid_d           = {valid_q[LAT-1:0], in_valid};
        op_d[0]           = op;
        for (int k = 1; k < LAT; k++) begin
            op_d[k] = op_q[k-1];
        end
        for (int k = 1; k <= LAT; k++) begin
            for (int i = 0; i < WIDTH / 2; i++) begin
                if (i < (WIDTH >> k)) begin
                    red_bit = reduce2(op_q[k-1],
                                      data_q[lvl_off(k-1) + 2*i],
                                      data_q[lvl_off(k-1) + 2*i + 1]);
                    if (k == LAT) begin
                        // Final bit is the visible result: it holds across bubbles.
                        if (valid_q[LAT-1]) begin
                            data_d[FINAL_BIT] = red_bit ^ (op_q[LAT-1] == 2'b11);
                        end
                    end else begin
                        data_d[lvl_off(k) + i] = red_bit;
                    end
                end
            end
        end
    end

    // Clear is applied first so a result on the same edge still counts.
    always_comb begin
        any_seen_d  = clear ? 1'b0  : any_seen_q;
        hit_count_d = clear ? 16'd0 : hit_count_q;
        if (valid_q[LAT] && data_q[FINAL_BIT]) begin
            any_seen_d = 1'b1;
            if (hit_count_d != 16'hFFFF) begin
                hit_count_d = hit_count_d + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q      <= '0;
            valid_q     <= '0;
            op_q        <= '0;
            any_seen_q  <= 1'b0;
            hit_count_q <= 16'd0;
        end else begin
            data_q      <= data_d;
            valid_q     <= valid_d;
            op_q        <= op_d;
            any_seen_q  <= any_seen_d;
            hit_count_q <= hit_count_d;
        end
    end

    assign out_valid = valid_q[LAT];
    assign out       = data_q[FINAL_BIT];
    assign any_seen  = any_seen_q;
    assign hit_count = hit_count_q;

endmodule

`default_nettype wire

// File: tb/tb_or_nway_pipe.sv
// ============================================================================
// Module   : tb_or_nway_pipe
// Purpose  : Scoreboard bench for or_nway_pipe (WIDTH=8 and WIDTH=64 instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_or_nway_pipe;

    localparam int W8    = 8;
    localparam int LAT8  = 3;
    localparam int W64   = 64;
    localparam int LAT64 = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        clear = 1'b0;
    logic [7:0]  din = '0;
    logic [63:0] din64 = '0;
    logic [1:0]  op = '0;

    logic        out_valid, out, any_seen;
    logic [15:0] hit_count;
    logic        out_valid64, out64, any_seen64;
    logic [15:0] hit_count64;

    or_nway_pipe #(.WIDTH(W8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(din), .op(op), .clear(clear),
        .out_valid(out_valid), .out(out), .any_seen(any_seen), .hit_count(hit_count)
    );

    or_nway_pipe #(.WIDTH(W64)) dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(din64), .op(op), .clear(clear),
        .out_valid(out_valid64), .out(out64), .any_seen(any_seen64), .hit_count(hit_count64)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int due;
        bit val;
    } exp_t;

    exp_t q8[$];
    exp_t q64[$];
    int   checks = 0;
    int   failures = 0;
    bit   m_seen = 1'b0;
    int   m_hit = 0;
    bit   last8 = 1'b0;
    bit   last64 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Reference: reduce the low w bits of v according to op.
    function automatic bit ref_red(input logic [63:0] v, input int w, input logic [1:0] o);
        logic [63:0] m;
        m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        case (o)
            2'b00:   return |(v & m);
            2'b01:   return &(v | ~m);
            2'b10:   return ^(v & m);
            default: return ~|(v & m);
        endcase
    endfunction

    task automatic drive(input bit v, input logic [7:0] d, input logic [1:0] o,
                         input bit c, input logic [63:0] d64);
        @(posedge clk);
        #1;
        in_valid = v;
        din      = d;
        op       = o;
        clear    = c;
        din64    = d64;
        if (v) begin
            q8.push_back('{cyc + 1 + LAT8, ref_red({56'd0, d}, W8, o)});
            q64.push_back('{cyc + 1 + LAT64, ref_red(d64, W64, o)});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 2'b00, 1'b0, 64'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_out", {31'd0, out}, 32'd0);
        check("async_rst_any_seen", {31'd0, any_seen}, 32'd0);
        check("async_rst_hit_count", {16'd0, hit_count}, 32'd0);
        q8.delete();
        q64.delete();
        m_seen = 1'b0;
        m_hit  = 0;
        last8  = 1'b0;
        last64 = 1'b0;
        #1;
        reset = 1'b0;
    endtask

    // Monitor for the WIDTH=8 instance, including the counter model.
    always @(negedge clk) begin
        exp_t e;
        bit   ev;
        bit   eo;
        while (q8.size() > 0 && q8[0].due < cyc) begin
            e = q8.pop_front();
            checks++;
            failures++;
            $display("FAIL w8_missing_result cycle=%0d got=none expected=%0b due=%0d", cyc, e.val, e.due);
        end
        ev = (q8.size() > 0) && (q8[0].due == cyc);
        if (ev) begin
            e     = q8.pop_front();
            eo    = e.val;
            last8 = eo;
        end else begin
            eo = last8;
        end
        check("w8_out_valid", {31'd0, out_valid}, {31'd0, ev});
        check("w8_out", {31'd0, out}, {31'd0, eo});
        check("w8_any_seen", {31'd0, any_seen}, {31'd0, m_seen});
        check("w8_hit_count", {16'd0, hit_count}, m_hit);
        if (clear) begin
            m_seen = 1'b0;
            m_hit  = 0;
        end
        if (ev && eo) begin
            m_seen = 1'b1;
            if (m_hit < 65535) m_hit++;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        bit   ev;
        bit   eo;
        while (q64.size() > 0 && q64[0].due < cyc) begin
            e = q64.pop_front();
            checks++;
            failures++;
            $display("FAIL w64_missing_result cycle=%0d got=none expected=%0b due=%0d", cyc, e.val, e.due);
        end
        ev = (q64.size() > 0) && (q64[0].due == cyc);
        if (ev) begin
            e      = q64.pop_front();
            eo     = e.val;
            last64 = eo;
        end else begin
            eo = last64;
        end
        check("w64_out_valid", {31'd0, out_valid64}, {31'd0, ev});
        check("w64_out", {31'd0, out64}, {31'd0, eo});
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $fatal(1);
    end

    initial begin
        logic [7:0]  sweep [6];
        logic [7:0]  mix_d [5];
        logic [1:0]  mix_o [5];
        logic [7:0]  rd;
        logic [63:0] r64;
        int          sel;

        sweep = '{8'h00, 8'h01, 8'h08, 8'h80, 8'hFF, 8'hAA};
        mix_d = '{8'hFF, 8'hFE, 8'h03, 8'h07, 8'h00};
        mix_o = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_hit_count", {16'd0, hit_count}, 32'd0);

        // Release reset and present a sample for the very next edge.
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b1;
        din      = sweep[0];
        din64    = 64'h8000_0000_0000_0000;
        op       = 2'b00;
        q8.push_back('{cyc + 1 + LAT8, 1'b0});
        q64.push_back('{cyc + 1 + LAT64, 1'b1});
        for (int i = 1; i < 6; i++) drive(1'b1, sweep[i], 2'b00, 1'b0, 64'd0);
        idle(LAT8 + 2);
        check("sweep_hit_count", {16'd0, hit_count}, 32'd5);
        check("sweep_any_seen", {31'd0, any_seen}, 32'd1);

        for (int i = 0; i < 5; i++) drive(1'b1, mix_d[i], mix_o[i], 1'b0, {56'd0, mix_d[i]});
        idle(LAT64 + 1);

        drive(1'b1, 8'h01, 2'b00, 1'b0, 64'd1);
        drive(1'b0, 8'($urandom), 2'b00, 1'b0, 64'd0);
        drive(1'b1, 8'h00, 2'b00, 1'b0, 64'd0);
        idle(LAT64 + 1);

        drive(1'b0, 8'h00, 2'b00, 1'b1, 64'd0);
        idle(1);
        check("clear_idle_hit_count", {16'd0, hit_count}, 32'd0);
        check("clear_idle_any_seen", {31'd0, any_seen}, 32'd0);

        drive(1'b1, 8'hFF, 2'b00, 1'b0, 64'd0);
        idle(LAT8 + 2);
        drive(1'b1, 8'hFF, 2'b00, 1'b0, 64'd0);
        idle(LAT8);
        drive(1'b0, 8'h00, 2'b00, 1'b1, 64'd0);
        idle(1);
        check("clear_collide_hit_count", {16'd0, hit_count}, 32'd1);
        check("clear_collide_any_seen", {31'd0, any_seen}, 32'd1);
        idle(LAT64);

        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 3);
            rd  = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
            sel = $urandom_range(0, 3);
            r64 = (sel == 0) ? 64'd0 : (sel == 1) ? '1 :
                  (sel == 2) ? (64'd1 << $urandom_range(0, 63)) : {$urandom, $urandom};
            drive($urandom_range(0, 3) != 0, rd, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 15) == 0, r64);
        end

        drive(1'b1, 8'hFF, 2'b00, 1'b0, '1);
        drive(1'b1, 8'hFF, 2'b00, 1'b0, '1);
        pulse_reset();
        idle(LAT64 + 3);
        check("midflight_hit_count", {16'd0, hit_count}, 32'd0);
        check("midflight_out_valid", {31'd0, out_valid}, 32'd0);

        @(posedge clk);
        #1;
        force dut8.hit_count_q = 16'hFFFE;
        m_hit = 16'hFFFE;
        #1;
        release dut8.hit_count_q;
        for (int i = 0; i < 3; i++) drive(1'b1, 8'hFF, 2'b00, 1'b0, 64'd1);
        idle(LAT64 + 2);
        check("saturate_hit_count", {16'd0, hit_count}, 32'h0000FFFF);
        check("w64_any_seen", {31'd0, any_seen64}, 32'd1);
        check("w64_hit_count", {16'd0, hit_count64}, 32'd3);

        for (int i = 0; i < 20 && (q8.size() > 0 || q64.size() > 0); i++) idle(1);
        check("drain_q8", q8.size(), 32'd0);
        check("drain_q64", q64.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
